// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encoding and default divider timeout.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } state_e;

  localparam int DEFAULT_DIV_TIMEOUT = 64;

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Free-running wrap-around event counter with enable and async active-low reset.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: merges memory wait, divider handshake, branch redirect and
// load-use requests into per-stage enables/flushes, PC enable and performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = DEFAULT_DIV_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             hz_bubble,
  input  logic             ex_branch_taken,
  input  logic             ex_div_valid,
  input  logic             div_done,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             div_start,
  output logic             div_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int TW = $clog2(DIV_TIMEOUT + 1);

  // Divider handshake: div_start is a single-cycle request issued from RUN; the divider
  // answers with a single-cycle div_done. A done seen while memory is busy is parked in done_q.
  state_e        state_q, state_d;
  logic          done_q, done_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_q, tmo_d;

  logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_en_c, id_ex_flush_c;
  logic ex_mem_en_c, ex_mem_flush_c, mem_wb_flush_c, div_start_c;
  logic branch_act, release_div, tmo_hit;

  always_comb begin
    state_d        = state_q;
    done_d         = done_q;
    tmo_cnt_d      = tmo_cnt_q;
    tmo_d          = tmo_q;
    pc_en_c        = 1'b1;
    if_id_en_c     = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_en_c     = 1'b1;
    id_ex_flush_c  = 1'b0;
    ex_mem_en_c    = 1'b1;
    ex_mem_flush_c = 1'b0;
    mem_wb_flush_c = 1'b0;
    div_start_c    = 1'b0;
    branch_act     = 1'b0;

    release_div = (state_q == DIV_WAIT) && (div_done || done_q) && !dmem_busy;
    // The flag is visible in the same cycle the wait count reaches DIV_TIMEOUT.
    tmo_hit     = (state_q == DIV_WAIT) && (tmo_cnt_q == TW'(DIV_TIMEOUT - 1));
    if (tmo_hit) tmo_d = 1'b1;

    if (dmem_busy) begin
      pc_en_c        = 1'b0;
      if_id_en_c     = 1'b0;
      id_ex_en_c     = 1'b0;
      ex_mem_en_c    = 1'b0;
      mem_wb_flush_c = 1'b1;
      if ((state_q == DIV_WAIT) && div_done) done_d = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_div_valid) begin
            div_start_c    = 1'b1;
            state_d        = DIV_WAIT;
            pc_en_c        = 1'b0;
            if_id_en_c     = 1'b0;
            id_ex_en_c     = 1'b0;
            ex_mem_flush_c = 1'b1;
          end else if (ex_branch_taken) begin
            branch_act    = 1'b1;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (hz_stall || hz_bubble) begin
            pc_en_c       = 1'b0;
            if_id_en_c    = 1'b0;
            id_ex_flush_c = 1'b1;
          end
        end
        DIV_WAIT: begin
          if (release_div) begin
            state_d = RUN;
            done_d  = 1'b0;
          end else begin
            pc_en_c        = 1'b0;
            if_id_en_c     = 1'b0;
            id_ex_en_c     = 1'b0;
            ex_mem_flush_c = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end

    // Wait counter saturates once the timeout is reached; the flag itself is sticky.
    if (state_q == DIV_WAIT) begin
      if (release_div)  tmo_cnt_d = '0;
      else if (!tmo_hit) tmo_cnt_d = tmo_cnt_q + TW'(1);
    end else begin
      tmo_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      done_q    <= 1'b0;
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign pc_en        = pc_en_c        & rst_n;
  assign if_id_en     = if_id_en_c     & rst_n;
  assign if_id_flush  = if_id_flush_c  & rst_n;
  assign id_ex_en     = id_ex_en_c     & rst_n;
  assign id_ex_flush  = id_ex_flush_c  & rst_n;
  assign ex_mem_en    = ex_mem_en_c    & rst_n;
  assign ex_mem_flush = ex_mem_flush_c & rst_n;
  assign mem_wb_flush = mem_wb_flush_c & rst_n;
  assign div_start    = div_start_c    & rst_n;
  assign div_timeout  = (tmo_q | tmo_hit) & rst_n;

  perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!pc_en),
    .count (stall_cycles)
  );

  perf_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (branch_act),
    .count (flush_count)
  );

endmodule
